// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_responder data-memory model and its bench.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int          LANE_BITS = 8;
    localparam int          NUM_LANES = 4;
    localparam logic [3:0]  BE_ALL    = 4'hF;
    localparam logic [3:0]  BE_LANE0  = 4'b0001;

    // Word-index width for a given depth (clog2, at least 1).
    function automatic int idx_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < 32'(depth)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the CPU data port and mem_responder.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_array.sv
// Word-organised RAM: synchronous byte-enabled write, combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: storage has no reset; contents survive a responder reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (be_i[l]) mem_q[idx_i][l*LANE_BITS +: LANE_BITS] <= wdata_i[l*LANE_BITS +: LANE_BITS];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Stalling data-memory responder: one outstanding load/store, LATENCY wait cycles, error on bad address.
// Optional MEM_RESPONDER_TRACE_EN adds saturating accept/error counters on acc_count/err_count.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus
`ifdef MEM_RESPONDER_TRACE_EN
    ,
    output logic [15:0]       acc_count,
    output logic [15:0]       err_count
`endif
);

    localparam int          AW         = idx_width(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT        = 4'(LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        cur_we, cur_byte;
    logic [31:0] cur_addr, cur_wdata;
    logic        req_ready, rsp_valid, accept, commit;
    logic [1:0]  lane;
    logic        access_err;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rword, load_data;

    // With zero latency the commit edge is the accept edge, so the live bus is the source.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = bus.req_we;
            cur_byte  = bus.req_byte;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_byte  = byte_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        lane       = cur_addr[1:0];
        access_err = (cur_addr >= ADDR_LIMIT) || (!cur_byte && (lane != 2'd0));
        mem_be     = cur_byte ? (BE_LANE0 << lane) : BE_ALL;
        mem_wdata  = cur_byte ? {NUM_LANES{cur_wdata[7:0]}} : cur_wdata;
        load_data  = cur_byte ? {24'd0, mem_rword[{lane, 3'b000} +: 8]} : mem_rword;
    end

    assign mem_we = commit && cur_we && !access_err;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .idx_i   (cur_addr[2 +: AW]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rword)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = reset;
                if (bus.req_valid && reset) begin
                    accept  = 1'b1;
                    we_d    = bus.req_we;
                    byte_d  = bus.req_byte;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = LAT;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    commit  = reset;
                end
            end
            RESP: begin
                rsp_valid = reset;
                if (bus.rsp_ready && reset) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d   = access_err;
            rdata_d = (access_err || cur_we) ? 32'd0 : load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

`ifdef MEM_RESPONDER_TRACE_EN
    logic [15:0] acc_q, errc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            errc_q <= '0;
        end else begin
            if (accept && (acc_q != 16'hFFFF)) acc_q <= acc_q + 16'd1;
            if (commit && access_err && (errc_q != 16'hFFFF)) errc_q <= errc_q + 16'd1;
        end
    end

    assign acc_count = acc_q;
    assign err_count = errc_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=1 instance and a LATENCY=0 instance.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int          DEPTH    = 64;
    localparam logic [31:0] OOR_ADDR = 32'(4 << idx_width(DEPTH));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if if1();
    mem_responder_if if0();

`ifdef MEM_RESPONDER_TRACE_EN
    logic [15:0] acc1, errc1, acc0, errc0;
`endif

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
`ifdef MEM_RESPONDER_TRACE_EN
        , .acc_count (acc1), .err_count (errc1)
`endif
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0)
`ifdef MEM_RESPONDER_TRACE_EN
        , .acc_count (acc0), .err_count (errc0)
`endif
    );

    exp_t q1[$], q0[$];
    exp_t e1, e0;
    int   acc_cyc[2];
    int   first_cyc[2];
    bit   seen[2];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_acc  = 0;
    int   exp_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard on each response handshake.
    always @(negedge clk) begin
        if (!rst1) seen[1] = 1'b0;
        else if (if1.rsp_valid) begin
            if (!seen[1]) begin
                seen[1]      = 1'b1;
                first_cyc[1] = cyc;
            end
            if (if1.rsp_ready) begin
                seen[1] = 1'b0;
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut1 spurious response: got rdata 0x%08h, expected none", if1.rsp_rdata);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1 rsp_rdata", if1.rsp_rdata, e1.rdata);
                    check("dut1 rsp_err", 32'(if1.rsp_err), 32'(e1.err));
                    check("dut1 latency", 32'(first_cyc[1] - acc_cyc[1]), 32'(e1.lat));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst0) seen[0] = 1'b0;
        else if (if0.rsp_valid) begin
            if (!seen[0]) begin
                seen[0]      = 1'b1;
                first_cyc[0] = cyc;
            end
            if (if0.rsp_ready) begin
                seen[0] = 1'b0;
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut0 spurious response: got rdata 0x%08h, expected none", if0.rsp_rdata);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0 rsp_rdata", if0.rsp_rdata, e0.rdata);
                    check("dut0 rsp_err", 32'(if0.rsp_err), 32'(e0.err));
                    check("dut0 latency", 32'(first_cyc[0] - acc_cyc[0]), 32'(e0.lat));
                end
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic we, input logic bt,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 1) begin
            if1.req_valid = v; if1.req_we = we; if1.req_byte = bt;
            if1.req_addr  = a; if1.req_wdata = w;
        end else begin
            if0.req_valid = v; if0.req_we = we; if0.req_byte = bt;
            if0.req_addr  = a; if0.req_wdata = w;
        end
    endtask

    function automatic logic ready_of(input int d);
        return (d == 1) ? if1.req_ready : if0.req_ready;
    endfunction

    function automatic int pending(input int d);
        return (d == 1) ? q1.size() : q0.size();
    endfunction

    task automatic issue(input int d, input logic we, input logic bt,
                         input logic [31:0] a, input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        drive(d, 1'b1, we, bt, a, w);
        while (!ready_of(d) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("request accepted", 32'(ready_of(d)), 32'd1);
        acc_cyc[d] = cyc;
        @(posedge clk);
        #1 drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (pending(d) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("responses outstanding", 32'(pending(d)), 32'd0);
        if (d == 1) q1.delete(); else q0.delete();
    endtask

    task automatic req(input int d, input logic we, input logic bt, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = (d == 1) ? 2 : 1;
        if (d == 1) q1.push_back(e); else q0.push_back(e);
        issue(d, we, bt, a, w);
        wait_done(d);
        if (d == 1) begin
            exp_acc++;
            if (exp_err) exp_errs++;
        end
    endtask

    task automatic reset_dut(input int d);
        @(negedge clk);
        if (d == 1) rst1 = 1'b0; else rst0 = 1'b0;
        @(negedge clk);
        if (d == 1) begin
            check("dut1 reset req_ready", 32'(if1.req_ready), 32'd0);
            check("dut1 reset rsp_valid", 32'(if1.rsp_valid), 32'd0);
            check("dut1 reset rsp_rdata", if1.rsp_rdata, 32'd0);
            check("dut1 reset rsp_err", 32'(if1.rsp_err), 32'd0);
`ifdef MEM_RESPONDER_TRACE_EN
            check("dut1 reset acc_count", 32'(acc1), 32'd0);
            check("dut1 reset err_count", 32'(errc1), 32'd0);
`endif
            rst1     = 1'b1;
            exp_acc  = 0;
            exp_errs = 0;
        end else begin
            check("dut0 reset req_ready", 32'(if0.req_ready), 32'd0);
            check("dut0 reset rsp_valid", 32'(if0.rsp_valid), 32'd0);
            rst0 = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst1 = 1'b0;
        rst0 = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        if1.rsp_ready = 1'b1;
        if0.rsp_ready = 1'b1;

        reset_dut(1);
        reset_dut(0);
        @(negedge clk);
        check("dut1 idle req_ready", 32'(if1.req_ready), 32'd1);

        // Word store/load, byte lane merge, byte loads
        req(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        req(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        req(1, 1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
        req(1, 1'b1, 1'b1, 32'h13, 32'hFFFFFFAB, 32'h0, 1'b0);
        req(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB223344, 1'b0);
        req(1, 1'b0, 1'b1, 32'h12, 32'h0, 32'h00000022, 1'b0);
        req(1, 1'b0, 1'b1, 32'h13, 32'h0, 32'h000000AB, 1'b0);

        // Faults: misaligned word, out of range, faulting stores must not write
        req(1, 1'b0, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
        req(1, 1'b0, 1'b0, OOR_ADDR, 32'h0, 32'h0, 1'b1);
        req(1, 1'b1, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        req(1, 1'b1, 1'b1, OOR_ADDR, 32'h5A, 32'h0, 1'b1);
        req(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB223344, 1'b0);
        req(1, 1'b0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);

        // Last word of the array
        req(1, 1'b1, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0);
        req(1, 1'b0, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset while waiting drops the store
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h20, 32'h55);
        rst1 = 1'b0;
        @(negedge clk);
        check("dut1 rsp_valid in reset", 32'(if1.rsp_valid), 32'd0);
        check("dut1 req_ready in reset", 32'(if1.req_ready), 32'd0);
        @(negedge clk);
        rst1     = 1'b1;
        exp_acc  = 0;
        exp_errs = 0;
        req(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Reset while responding keeps the committed store
        if1.rsp_ready = 1'b0;
        issue(1, 1'b1, 1'b0, 32'h24, 32'h77);
        n = 0;
        while (!if1.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("dut1 rsp_valid before reset", 32'(if1.rsp_valid), 32'd1);
        rst1 = 1'b0;
        @(negedge clk);
        check("dut1 rsp_valid after reset", 32'(if1.rsp_valid), 32'd0);
        rst1          = 1'b1;
        if1.rsp_ready = 1'b1;
        exp_acc       = 0;
        exp_errs      = 0;
        req(1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h77, 1'b0);

        // Three good accesses and two faults since the last reset
        req(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hAB223344, 1'b0);
        req(1, 1'b0, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
        req(1, 1'b0, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
        req(1, 1'b0, 1'b0, OOR_ADDR, 32'h0, 32'h0, 1'b1);
`ifdef MEM_RESPONDER_TRACE_EN
        @(negedge clk);
        check("dut1 acc_count", 32'(acc1), 32'(exp_acc));
        check("dut1 err_count", 32'(errc1), 32'(exp_errs));
`endif

        // Zero-latency instance with backpressure
        req(0, 1'b1, 1'b0, 32'h08, 32'h12345678, 32'h0, 1'b0);
        req(0, 1'b0, 1'b1, 32'h09, 32'h0, 32'h00000056, 1'b0);
        begin
            exp_t e;
            e.rdata = 32'h12345678;
            e.err   = 1'b0;
            e.lat   = 1;
            q0.push_back(e);
        end
        if0.rsp_ready = 1'b0;
        issue(0, 1'b0, 1'b0, 32'h08, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 1'b1, 1'b0, 32'h08, 32'hFFFFFFFF);
            check("dut0 held rsp_valid", 32'(if0.rsp_valid), 32'd1);
            check("dut0 held rsp_rdata", if0.rsp_rdata, 32'h12345678);
            check("dut0 held req_ready", 32'(if0.req_ready), 32'd0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        if0.rsp_ready = 1'b1;
        wait_done(0);
        req(0, 1'b0, 1'b0, 32'h08, 32'h0, 32'h12345678, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
